rf_wb_ctrl: RTL
===============

Name: rf_wb_ctrl

Overview:
- Write-side controller for the 32-entry integer register file: owns the single RF write port (wr_en/rd_addr/rd_data).
- Arbitrates between the single-cycle ALU writeback path and the multi-cycle load-response path.
- Tracks outstanding loads in a per-register busy scoreboard so issue logic can stall RAW/WAW hazards.
- Sits between execute/LSU and the register file in the multi-cycle core.

Parameters:
- DW, 32, register data width.
- NREG, 32, number of architectural registers; register x0 is hardwired zero.
- RAW, 5, register address width, equal to clog2(NREG).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- alu_wb_valid  in  1  ALU result valid this cycle; no backpressure.
- alu_wb_rd  in  RAW  ALU destination register.
- alu_wb_data  in  DW  ALU result.
- ld_issue_valid  in  1  load issued to memory this cycle.
- ld_issue_rd  in  RAW  destination register of the issued load.
- ld_rsp_valid  in  1  load data available.
- ld_rsp_ready  out  1  load response accepted.
- ld_rsp_rd  in  RAW  load destination register.
- ld_rsp_data  in  DW  load data, already sign/zero extended.
- rs1_addr  in  RAW  hazard query 1.
- rs2_addr  in  RAW  hazard query 2.
- rs1_busy  out  1  rs1_addr has a pending load.
- rs2_busy  out  1  rs2_addr has a pending load.
- rf_wr_en  out  1  RF write enable.
- rf_rd_addr  out  RAW  RF write address.
- rf_rd_data  out  DW  RF write data.
- pending_cnt  out  clog2(NREG+1)  outstanding load count.
- err  out  1  sticky protocol error.

Behaviour:
- **Reset:** rst asserted clears rf_wr_en, rf_rd_addr, rf_rd_data, all busy bits, pending_cnt and err to 0 asynchronously. Any in-flight writeback is dropped.
- **Write port:** fully registered. A source accepted in cycle t drives rf_wr_en=1 with its addr/data during cycle t+1. The RF captures the write at the end of t+1. rf_wr_en=0 in every other cycle.
- **Arbitration:** the ALU has fixed priority.
  - ld_rsp_ready = !alu_wb_valid, combinational. It is 0 during rst.
  - A load is accepted when ld_rsp_valid && ld_rsp_ready.
  - The load side must hold valid/rd/data stable until accepted.
- **x0 handling:** a writeback with rd==0, from either source, is consumed (load handshake still completes) but produces rf_wr_en=0.
- **Scoreboard set:** ld_issue_valid with ld_issue_rd!=0 sets busy[rd] at the next edge and increments pending_cnt. An issue to x0 changes neither.
- **Scoreboard clear:** busy[rd] clears, and pending_cnt decrements, at the edge ending the rf_wr_en cycle of that load. busy therefore drops exactly when the RF holds the data, since the RF has no write bypass.
- **Load to x0:** a load response to x0 has no busy bit to clear and leaves pending_cnt unchanged.
- **Busy outputs:** rs1_busy = busy[rs1_addr], rs2_busy = busy[rs2_addr]. Both are combinational from registered state and forced to 0 for address 0.
- **Simultaneous set and clear on the same register:** the set wins, so busy stays 1. pending_cnt is net unchanged.
- **Simultaneous set and clear on different registers:** both take effect, and pending_cnt is net unchanged.
- **Error conditions:** err is set and held until rst on any of:
  - ld_issue to an already-busy register (WAW not stalled);
  - accepted ld_rsp to a non-busy nonzero register;
  - alu_wb_valid to a busy register;
  - pending_cnt overflow or underflow.
  
  The offending write still proceeds, and the counter saturates.
- **Throughput:** one RF write per cycle. The load path is starved while the ALU is valid every cycle; no fairness is guaranteed.

Decomposition:
- Package rf_wb_pkg holds:
  - typedef reg_addr_t (logic [RAW-1:0]);
  - constants NREG=32 and REG_ZERO=0;
  - enum wb_src_e {WB_NONE, WB_ALU, WB_LD}, which records the source of the registered write so busy is cleared only for loads.
- Sub-module rf_scoreboard holds the busy vector, pending counter, two read ports and the set/clear/err logic. rf_wb_ctrl contains the arbiter and write-port registers.

Test Plan:
- Reset mid-writeback: alu_wb x5=0xDEADBEEF, assert rst in the following cycle -> rf_wr_en=0, busy all 0, pending_cnt=0, err=0 immediately.
- ALU write:
  - alu_wb x3=0x1234 at t -> rf_wr_en=1, addr=3, data=0x1234 at t+1.
  - alu_wb x0=0xFFFF -> rf_wr_en stays 0.
- Load lifecycle:
  - issue x7 at t -> rs1_busy=1 (rs1_addr=7) and pending_cnt=1 from t+1.
  - rsp x7=0xCAFE accepted at t+4 -> rf write at t+5; rs1_busy=0 and pending_cnt=0 from t+6.
- Conflict: alu_wb x1 and ld_rsp x2 both valid at t -> ld_rsp_ready=0 at t, ALU written at t+1. With the ALU idle at t+1 -> load accepted t+1, written t+2.
- Same-cycle set and clear: write-cycle for load x4 coincides with a new issue to x4 -> busy[4] stays 1, pending_cnt unchanged, err=0.
- Error paths, each checked after rst:
  - issue x9 twice without a response -> err=1 and stays 1;
  - alu_wb to busy x9 -> err=1;
  - ld_rsp to non-busy x10 -> err=1 and the write still occurs.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the integer register-file write-side controller.
// Holds the register address type and the tag that names the source of a registered write.
package rf_wb_pkg;

   localparam int DW   = 32;
   localparam int NREG = 32;
   localparam int RAW  = $clog2(NREG);

   typedef logic [RAW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;

   // Source of the write currently on the RF port; only loads release a busy bit.
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LD   = 2'd2
   } wb_src_e;

endpackage

// File: rtl/rf_wb_ctrl_scoreboard.sv
// Per-register busy scoreboard for outstanding loads: busy vector, pending counter,
// two hazard read ports and the sticky protocol error flag.
module rf_scoreboard #(
   parameter int NREG = rf_wb_pkg::NREG,
   parameter int RAW  = rf_wb_pkg::RAW,
   parameter int CW   = $clog2(NREG + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           set_valid,
   input  logic [RAW-1:0] set_addr,
   input  logic           clr_valid,
   input  logic [RAW-1:0] clr_addr,
   input  logic           alu_chk_valid,
   input  logic [RAW-1:0] alu_chk_addr,
   input  logic           rsp_chk_valid,
   input  logic [RAW-1:0] rsp_chk_addr,
   input  logic [RAW-1:0] rs1_addr,
   input  logic [RAW-1:0] rs2_addr,
   output logic           rs1_busy,
   output logic           rs2_busy,
   output logic [CW-1:0]  pending_cnt,
   output logic           err
);
   import rf_wb_pkg::*;

   localparam logic [CW-1:0]  CNT_MAX = CW'(NREG);
   localparam logic [RAW-1:0] ZERO_A  = RAW'(REG_ZERO);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic            err_q;
   logic            err_d;
   logic            inc;
   logic            dec;
   logic            ovf;
   logic            unf;
   logic            waw_err;
   logic            alu_err;
   logic            rsp_err;

   function automatic logic is_busy(input logic [NREG-1:0] vec, input logic [RAW-1:0] addr);
      return (addr != ZERO_A) && vec[addr];
   endfunction

   always_comb begin
      inc    = set_valid && (set_addr != ZERO_A);
      dec    = clr_valid && (clr_addr != ZERO_A);
      busy_d = busy_q;
      if (dec) begin
         busy_d[clr_addr] = 1'b0;
      end
      // Applied after the clear so a same-register set wins.
      if (inc) begin
         busy_d[set_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      ovf   = 1'b0;
      unf   = 1'b0;
      case ({inc, dec})
         2'b10: begin
            if (cnt_q == CNT_MAX) ovf = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
         end
         2'b01: begin
            if (cnt_q == '0) unf = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      // A reissue landing on the very edge that retires the old load is legal.
      waw_err = inc && busy_q[set_addr] && !(dec && (clr_addr == set_addr));
      alu_err = alu_chk_valid && is_busy(busy_q, alu_chk_addr);
      rsp_err = rsp_chk_valid && (rsp_chk_addr != ZERO_A) && !busy_q[rsp_chk_addr];
      err_d   = err_q || waw_err || alu_err || rsp_err || ovf || unf;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign rs1_busy    = is_busy(busy_q, rs1_addr);
   assign rs2_busy    = is_busy(busy_q, rs2_addr);
   assign pending_cnt = cnt_q;
   assign err         = err_q;

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: fixed-priority ALU/load arbiter feeding a fully
// registered write port, plus the load busy scoreboard used for hazard stalls.
module rf_wb_ctrl #(
   parameter int DW   = rf_wb_pkg::DW,
   parameter int NREG = rf_wb_pkg::NREG,
   parameter int RAW  = rf_wb_pkg::RAW
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alu_wb_valid,
   input  logic [RAW-1:0]              alu_wb_rd,
   input  logic [DW-1:0]               alu_wb_data,
   input  logic                        ld_issue_valid,
   input  logic [RAW-1:0]              ld_issue_rd,
   input  logic                        ld_rsp_valid,
   output logic                        ld_rsp_ready,
   input  logic [RAW-1:0]              ld_rsp_rd,
   input  logic [DW-1:0]               ld_rsp_data,
   input  logic [RAW-1:0]              rs1_addr,
   input  logic [RAW-1:0]              rs2_addr,
   output logic                        rs1_busy,
   output logic                        rs2_busy,
   output logic                        rf_wr_en,
   output logic [RAW-1:0]              rf_rd_addr,
   output logic [DW-1:0]               rf_rd_data,
   output logic [$clog2(NREG+1)-1:0]   pending_cnt,
   output logic                        err
);
   import rf_wb_pkg::*;

   localparam int             CW     = $clog2(NREG + 1);
   localparam logic [RAW-1:0] ZERO_A = RAW'(REG_ZERO);

   logic           ld_acc;
   logic           en_d;
   logic [RAW-1:0] addr_d;
   logic [DW-1:0]  data_d;
   wb_src_e        src_d;
   wb_src_e        src_q;
   logic           ld_clr;

   // Load side: valid/rd/data held by the LSU until ready; ALU never waits.
   assign ld_rsp_ready = !alu_wb_valid && !rst;
   assign ld_acc       = ld_rsp_valid && ld_rsp_ready;

   always_comb begin
      en_d   = 1'b0;
      addr_d = rf_rd_addr;
      data_d = rf_rd_data;
      src_d  = WB_NONE;
      if (alu_wb_valid) begin
         en_d   = (alu_wb_rd != ZERO_A);
         addr_d = alu_wb_rd;
         data_d = alu_wb_data;
         src_d  = WB_ALU;
      end else if (ld_acc) begin
         en_d   = (ld_rsp_rd != ZERO_A);
         addr_d = ld_rsp_rd;
         data_d = ld_rsp_data;
         src_d  = WB_LD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_wr_en   <= 1'b0;
         rf_rd_addr <= '0;
         rf_rd_data <= '0;
         src_q      <= WB_NONE;
      end else begin
         rf_wr_en   <= en_d;
         rf_rd_addr <= addr_d;
         rf_rd_data <= data_d;
         src_q      <= src_d;
      end
   end

   // Busy releases on the edge that ends the load's write cycle, when the RF holds the data.
   assign ld_clr = rf_wr_en && (src_q == WB_LD);

   rf_scoreboard #(
      .NREG (NREG),
      .RAW  (RAW),
      .CW   (CW)
   ) u_sb (
      .clk           (clk),
      .rst           (rst),
      .set_valid     (ld_issue_valid),
      .set_addr      (ld_issue_rd),
      .clr_valid     (ld_clr),
      .clr_addr      (rf_rd_addr),
      .alu_chk_valid (alu_wb_valid),
      .alu_chk_addr  (alu_wb_rd),
      .rsp_chk_valid (ld_acc),
      .rsp_chk_addr  (ld_rsp_rd),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .pending_cnt   (pending_cnt),
      .err           (err)
   );

endmodule
